// File: rtl/prach_hb3_sched.sv
// -----------------------------------------------------------------------------
// prach_hb3_sched
//
// Pairs consecutive samples of each TDM channel for a half-band (decimate-by-2)
// filter stage. The first sample of a channel (even phase) is parked in a
// per-channel buffer; the second (odd phase) releases the pair one clock later
// together with the channel index. A frame-start pulse clears all phases and
// is re-emitted as sync_out on the first channel-0 pair that follows it.
//
// Optional feature (compile-time macro PRACH_HB3_SCHED_SEQCHK_EN):
//   channel-sequence checker driving the sticky err_seq flag. Without the
//   macro err_seq is tied to 0 and no tracker logic is built.
//
// Parameters
//   NUM_CHN  number of active TDM channels (0..NUM_CHN-1)
//   DW       sample width
//   CW       channel index width
//
// Ports
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   din_dq    signed input sample
//   din_dv    input sample valid
//   din_chn   channel index of din_dq
//   sync_in   single-cycle frame-start pulse
//   dout_dp1  older (even-phase) sample of the pair
//   dout_dp2  newer (odd-phase) sample of the pair
//   dout_dv   pair valid (one cycle per pair)
//   dout_chn  channel index of the pair
//   sync_out  frame-start marker aligned to the channel-0 pair
//   err_seq   sticky channel-sequence error
// -----------------------------------------------------------------------------
module prach_hb3_sched #(
    parameter int NUM_CHN = 48,
    parameter int DW      = 16,
    parameter int CW      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] din_dq,
    input  logic                 din_dv,
    input  logic [CW-1:0]        din_chn,
    input  logic                 sync_in,
    output logic signed [DW-1:0] dout_dp1,
    output logic signed [DW-1:0] dout_dp2,
    output logic                 dout_dv,
    output logic [CW-1:0]        dout_chn,
    output logic                 sync_out,
    output logic                 err_seq
);

    localparam int            IW       = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [CW-1:0] LAST_CHN = CW'(NUM_CHN - 1);

    logic [NUM_CHN-1:0]   phase;
    logic signed [DW-1:0] smp_buf [NUM_CHN];
    logic                 pending;

    logic                 in_rng;
    logic [IW-1:0]        idx;
    logic                 odd_hit;
    logic                 sync_fire;

    logic signed [DW-1:0] dp1_p1;
    logic signed [DW-1:0] dp2_p1;
    logic [CW-1:0]        chn_p1;
    logic                 vld_p1;
    logic                 sync_p1;

    assign in_rng    = din_dv && (din_chn <= LAST_CHN);
    assign idx       = din_chn[IW-1:0];
    // sync_in forces the current sample to be treated as even phase
    assign odd_hit   = in_rng && !sync_in && phase[idx];
    assign sync_fire = odd_hit && (din_chn == '0) && pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase   <= '0;
            pending <= 1'b0;
        end else begin
            if (sync_in)
                phase <= '0;
            if (in_rng)
                phase[idx] <= ~odd_hit;
            // a repeated sync_in simply keeps the flag armed
            pending <= sync_in | (pending & ~sync_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (in_rng && !odd_hit)
            smp_buf[idx] <= din_dq;
    end

    // ---- stage p1: registered pair output ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            sync_p1 <= 1'b0;
            dp1_p1  <= '0;
            dp2_p1  <= '0;
            chn_p1  <= '0;
        end else begin
            vld_p1  <= odd_hit;
            sync_p1 <= sync_fire;
            if (odd_hit) begin
                dp1_p1 <= smp_buf[idx];
                dp2_p1 <= din_dq;
                chn_p1 <= din_chn;
            end
        end
    end

    assign dout_dp1 = dp1_p1;
    assign dout_dp2 = dp2_p1;
    assign dout_chn = chn_p1;
    assign dout_dv  = vld_p1;
    assign sync_out = sync_p1;

`ifdef PRACH_HB3_SCHED_SEQCHK_EN
    logic [CW-1:0] exp_chn;
    logic [CW-1:0] ref_chn;
    logic          err_r;

    // sync_in restarts the expected sequence at 0 for the sample in the same cycle
    assign ref_chn = sync_in ? '0 : exp_chn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_chn <= '0;
            err_r   <= 1'b0;
        end else if (din_dv) begin
            if (din_chn != ref_chn)
                err_r <= 1'b1;
            exp_chn <= (din_chn == LAST_CHN) ? '0 : din_chn + CW'(1);
        end else if (sync_in) begin
            exp_chn <= '0;
        end
    end

    assign err_seq = err_r;
`else
    assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_prach_hb3_sched.sv
// -----------------------------------------------------------------------------
// tb_prach_hb3_sched
//
// Bench for prach_hb3_sched. Every cycle the outputs are compared against a
// reference model that tracks, per channel, whether a first sample is being
// held and what its value is, plus the frame-start pending state. Directed
// scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_prach_hb3_sched;

    localparam int NCH = 48;
    localparam int DW  = 16;
    localparam int CW  = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din_dq;
    logic          din_dv;
    logic [CW-1:0] din_chn;
    logic          sync_in;
    logic [DW-1:0] dout_dp1;
    logic [DW-1:0] dout_dp2;
    logic          dout_dv;
    logic [CW-1:0] dout_chn;
    logic          sync_out;
    logic          err_seq;

    prach_hb3_sched #(.NUM_CHN(NCH), .DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .err_seq  (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int unsigned held_val [NCH];
    bit          held_ok  [NCH];
    bit          m_pending;
    int unsigned m_dp1, m_dp2, m_chn;
    bit          m_dv, m_sync, m_err;
    int          m_exp_chn;

    int n_checks = 0;
    int n_pass   = 0;
    int dv_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model(input bit rn, input bit dv, input int unsigned ch,
                         input int unsigned dq, input bit sy);
        if (!rn) begin
            for (int i = 0; i < NCH; i++) held_ok[i] = 1'b0;
            m_pending = 0; m_dv = 0; m_sync = 0; m_err = 0;
            m_dp1 = 0; m_dp2 = 0; m_chn = 0; m_exp_chn = 0;
            return;
        end
        m_dv   = 0;
        m_sync = 0;
`ifdef PRACH_HB3_SCHED_SEQCHK_EN
        if (sy) m_exp_chn = 0;
        if (dv) begin
            if (ch != m_exp_chn) m_err = 1;
            m_exp_chn = (ch == NCH - 1) ? 0 : ((ch + 1) % 256);
        end
`endif
        if (sy) begin
            for (int i = 0; i < NCH; i++) held_ok[i] = 1'b0;
            m_pending = 1;
        end
        if (dv && ch < NCH) begin
            if (held_ok[ch]) begin
                m_dv  = 1;
                m_dp1 = held_val[ch];
                m_dp2 = dq;
                m_chn = ch;
                held_ok[ch] = 1'b0;
                if (ch == 0 && m_pending) begin
                    m_sync    = 1;
                    m_pending = 0;
                end
            end else begin
                held_val[ch] = dq;
                held_ok[ch]  = 1'b1;
            end
        end
    endtask

    // drive one cycle of inputs, advance the model, then compare at the falling edge
    task automatic step(input bit rn, input bit dv, input int unsigned ch,
                        input int unsigned dq, input bit sy);
        rst_n   = rn;
        din_dv  = dv;
        din_chn = CW'(ch);
        din_dq  = DW'(dq);
        sync_in = sy;
        model(rn, dv, ch, dq % 65536, sy);
        @(posedge clk);
        @(negedge clk);
        check("dout_dv",  {31'd0, dout_dv},  {31'd0, m_dv});
        check("sync_out", {31'd0, sync_out}, {31'd0, m_sync});
        check("err_seq",  {31'd0, err_seq},  {31'd0, m_err});
        check("dout_dp1", {16'd0, dout_dp1}, m_dp1);
        check("dout_dp2", {16'd0, dout_dp2}, m_dp2);
        check("dout_chn", {24'd0, dout_chn}, m_chn);
        if (dout_dv) dv_seen++;
    endtask

    initial begin
        int unsigned r, ch, dq;
        bit dv, sy, rn;

        rst_n = 1'b0; din_dv = 1'b0; din_chn = '0; din_dq = '0; sync_in = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 1, 3, 16'hBEEF, 0);

        // full frame pairing with sync alignment
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < NCH; i++) step(1, 1, i, i, 0);
        for (int i = 0; i < NCH; i++) step(1, 1, i, 100 + i, 0);
        step(1, 0, 0, 0, 0);

        // out-of-range channel is dropped
        step(1, 1, 50, 16'h7777, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 255, 16'h8888, 0);

        // sync discards an even sample; same-cycle sample becomes the new even
        step(1, 1, 5, 16'h1234, 0);
        step(1, 1, 5, 16'h5678, 1);
        step(1, 1, 5, 16'h0001, 0);
        check("pair_ch5_dp1", {16'd0, dout_dp1}, 32'h5678);
        check("pair_ch5_dp2", {16'd0, dout_dp2}, 32'h0001);

        // reset between even and odd samples of channel 3
        step(1, 1, 3, 16'hAAAA, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 3, 16'hBBBB, 0);
        step(1, 1, 3, 16'hCCCC, 0);
        check("pair_ch3_dp1", {16'd0, dout_dp1}, 32'hBBBB);

        // second sync while pending: single sync_out only
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 16'h0101, 1);
        step(1, 1, 0, 16'h1111, 0);
        step(1, 1, 0, 16'h2222, 0);
        step(1, 1, 0, 16'h3333, 0);
        step(1, 1, 0, 16'h4444, 0);

        // continuous valid input for four frames
        dv_seen = 0;
        step(1, 1, 0, $urandom_range(0, 65535), 1);
        for (int i = 1; i < 4 * NCH; i++) step(1, 1, i % NCH, $urandom_range(0, 65535), 0);
        check("burst_pairs", dv_seen, 96);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r  = $urandom_range(0, 99);
            rn = (r != 0);
            dv = ($urandom_range(0, 99) < 85);
            ch = ($urandom_range(0, 19) == 0) ? $urandom_range(NCH, 255) : $urandom_range(0, 7);
            dq = $urandom_range(0, 65535);
            sy = ($urandom_range(0, 99) < 4);
            step(rn, dv, ch, dq, sy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
